// File: rtl/dm_timer.sv
// -----------------------------------------------------------------------------
// dm_timer
//   Memory-mapped machine timer living on the core's data-memory bus. It decodes
//   the same address/data/strobe signals the core drives toward data RAM and
//   answers loads with the same one-cycle latency as that RAM. A level timer
//   interrupt request is produced for the MTI slot of the interrupt vector.
//
//   Register window (32 bytes at BASE, doubleword registers):
//     0x00 MTIME     free-running counter, RW
//     0x08 MTIMECMP  compare value, RW
//     0x10 CTRL      bit0 EN, bit1 IE, bits[15:8] PRESC, RW
//     0x18 STATUS    bit0 PEND, sticky, write-1-to-clear
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   reset          asynchronous active-low reset
//   DM_addr        byte address from the core
//   DM_writeData   store data (full doubleword only)
//   DM_writeEnable store strobe, one cycle per store
//   DM_readEnable  load strobe, one cycle per load
//   readData       registered load data, holds until the next hit load
//   rd_hit         one-cycle pulse, high while readData is valid from this block
//   timer_irq      registered level interrupt request (IE & match)
//
// Bus protocol: a strobe (DM_readEnable or DM_writeEnable) is a complete request
// in the cycle it is sampled; there is no ready/stall. Stores take effect at the
// sampling edge, loads present data (and rd_hit) in the following cycle.
// -----------------------------------------------------------------------------
module dm_timer #(
    parameter int          N    = 64,
    parameter logic [N-1:0] BASE = 'h2000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] DM_addr,
    input  logic [N-1:0] DM_writeData,
    input  logic         DM_writeEnable,
    input  logic         DM_readEnable,
    output logic [N-1:0] readData,
    output logic         rd_hit,
    output logic         timer_irq
);

    localparam logic [1:0] SEL_MTIME    = 2'd0;
    localparam logic [1:0] SEL_MTIMECMP = 2'd1;
    localparam logic [1:0] SEL_CTRL     = 2'd2;
    localparam logic [1:0] SEL_STATUS   = 2'd3;

    // Architectural state
    logic [N-1:0] mtime;
    logic [N-1:0] mtimecmp;
    logic         ctrlEn;
    logic         ctrlIe;
    logic [7:0]   ctrlPresc;
    logic         pend;
    logic [7:0]   prescCnt;

    // Decode
    logic       hit;
    logic [1:0] regSel;
    logic       wrMtime;
    logic       wrMtimecmp;
    logic       wrCtrl;
    logic       wrStatus;
    logic       loadHit;

    // Byte-within-doubleword bits play no part in the decode.
    logic unusedAddrBits;
    assign unusedAddrBits = ^DM_addr[2:0];

    assign hit        = (DM_addr[N-1:5] == BASE[N-1:5]);
    assign regSel     = DM_addr[4:3];
    assign wrMtime    = DM_writeEnable & hit & (regSel == SEL_MTIME);
    assign wrMtimecmp = DM_writeEnable & hit & (regSel == SEL_MTIMECMP);
    assign wrCtrl     = DM_writeEnable & hit & (regSel == SEL_CTRL);
    assign wrStatus   = DM_writeEnable & hit & (regSel == SEL_STATUS);
    assign loadHit    = DM_readEnable & hit;

    // Compare uses current register values, so a store to MTIME or MTIMECMP
    // only influences match from the following cycle on.
    logic match;
    assign match = (mtime >= mtimecmp);

    // Counter / prescaler next state. A store to MTIME wins over the tick;
    // a store to CTRL restarts the prescaler and swallows this cycle's tick.
    logic         tick;
    logic [N-1:0] mtimeNext;
    logic [7:0]   prescCntNext;

    assign tick = ctrlEn & (prescCnt == ctrlPresc);

    always_comb begin
        mtimeNext    = mtime;
        prescCntNext = prescCnt;
        if (wrMtime) begin
            mtimeNext    = DM_writeData;
            prescCntNext = 8'd0;
        end else if (wrCtrl) begin
            prescCntNext = 8'd0;
        end else if (ctrlEn) begin
            if (tick) begin
                mtimeNext    = mtime + 1'b1;
                prescCntNext = 8'd0;
            end else begin
                prescCntNext = prescCnt + 8'd1;
            end
        end
    end

    // Sticky pending bit: a live match always sets it, so a clear only lands
    // in a cycle where the compare is false.
    logic pendNext;
    always_comb begin
        pendNext = pend;
        if (match)
            pendNext = 1'b1;
        else if (wrStatus && DM_writeData[0])
            pendNext = 1'b0;
    end

    // Load mux, built from pre-edge register values so a same-cycle store to
    // the same register returns the old contents.
    logic [N-1:0] readMux;
    always_comb begin
        readMux = '0;
        unique case (regSel)
            SEL_MTIME:    readMux = mtime;
            SEL_MTIMECMP: readMux = mtimecmp;
            SEL_CTRL:     readMux = {{(N-16){1'b0}}, ctrlPresc, 6'b0, ctrlIe, ctrlEn};
            SEL_STATUS:   readMux = {{(N-1){1'b0}}, pend};
            default:      readMux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            ctrlEn    <= 1'b0;
            ctrlIe    <= 1'b0;
            ctrlPresc <= 8'd0;
            pend      <= 1'b0;
            prescCnt  <= 8'd0;
            readData  <= '0;
            rd_hit    <= 1'b0;
            timer_irq <= 1'b0;
        end else begin
            mtime    <= mtimeNext;
            prescCnt <= prescCntNext;
            pend     <= pendNext;

            if (wrMtimecmp)
                mtimecmp <= DM_writeData;

            if (wrCtrl) begin
                ctrlEn    <= DM_writeData[0];
                ctrlIe    <= DM_writeData[1];
                ctrlPresc <= DM_writeData[15:8];
            end

            rd_hit <= loadHit;
            if (loadHit)
                readData <= readMux;

            timer_irq <= ctrlIe & match;
        end
    end

endmodule

// File: tb/tb_dm_timer.sv
module tb_dm_timer;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_we;
  logic        dm_re;
  logic [63:0] read_data;
  logic        rd_hit;
  logic        timer_irq;

  dm_timer #(.N(64), .BASE(64'h2000)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .DM_addr        (dm_addr),
    .DM_writeData   (dm_wdata),
    .DM_writeEnable (dm_we),
    .DM_readEnable  (dm_re),
    .readData       (read_data),
    .rd_hit         (rd_hit),
    .timer_irq      (timer_irq)
  );

  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  int checks = 0;
  int errors = 0;

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks: each bus task occupies exactly one rising edge and returns
  // 1 time unit after it, so consecutive calls are back-to-back cycles.
  // ---------------------------------------------------------------------------
  task automatic bus_cycle(input logic [63:0] addr, input logic [63:0] wdata,
                           input logic we, input logic re);
    @(negedge clk);
    dm_addr  = addr;
    dm_wdata = wdata;
    dm_we    = we;
    dm_re    = re;
    @(posedge clk);
    #1;
    dm_we = 1'b0;
    dm_re = 1'b0;
  endtask

  task automatic wr(input logic [63:0] addr, input logic [63:0] data);
    bus_cycle(addr, data, 1'b1, 1'b0);
  endtask

  task automatic rd_check(input string tag, input logic [63:0] addr, input logic [63:0] exp);
    bus_cycle(addr, 64'd0, 1'b0, 1'b1);
    check({tag, "_hit"}, {63'd0, rd_hit}, 64'd1);
    check(tag, read_data, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [63:0] presc_exp [9];

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n    = 1'b0;
    dm_addr  = 64'd0;
    dm_wdata = 64'd0;
    dm_we    = 1'b0;
    dm_re    = 1'b0;
    presc_exp = '{64'd12, 64'd12, 64'd12, 64'd12, 64'd13, 64'd13, 64'd13, 64'd13, 64'd14};

    #23;
    check("rst_read_data", read_data, 64'd0);
    check("rst_rd_hit", {63'd0, rd_hit}, 64'd0);
    check("rst_irq", {63'd0, timer_irq}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset values, back-to-back loads
    rd_check("rst_mtime", 64'h2000, 64'd0);
    rd_check("rst_mtimecmp", 64'h2008, ALL_ONES);
    rd_check("rst_ctrl", 64'h2010, 64'd0);
    rd_check("rst_status", 64'h2018, 64'd0);
    idle(1);
    check("rd_hit_pulse_end", {63'd0, rd_hit}, 64'd0);
    check("read_data_hold", read_data, 64'd0);

    // PRESC=0 counting and compare
    wr(64'h2008, 64'd10);
    wr(64'h2010, 64'h0003);            // CTRL write edge: no tick
    rd_check("cnt_e1", 64'h2000, 64'd0);
    rd_check("cnt_e2", 64'h2000, 64'd1);
    idle(8);                           // MTIME just became 10
    check("irq_not_yet", {63'd0, timer_irq}, 64'd0);
    idle(1);
    check("irq_rise", {63'd0, timer_irq}, 64'd1);
    rd_check("pend_set", 64'h2018, 64'd1);

    // PRESC=3: one increment every 4 cycles
    wr(64'h2010, 64'h0301);
    for (int i = 0; i < 9; i++) begin
      rd_check($sformatf("presc3_%0d", i), 64'h2000, presc_exp[i]);
    end
    wr(64'h2010, 64'd0);               // disable
    rd_check("frozen_a", 64'h2000, 64'd14);
    idle(5);
    rd_check("frozen_b", 64'h2000, 64'd14);
    check("irq_ie_off", {63'd0, timer_irq}, 64'd0);

    // Wrap and MTIME overwrite while counting
    wr(64'h2010, 64'h0001);
    wr(64'h2000, 64'hFFFF_FFFF_FFFF_FFFE);
    rd_check("wrap_fe", 64'h2000, 64'hFFFF_FFFF_FFFF_FFFE);
    rd_check("wrap_ff", 64'h2000, ALL_ONES);
    rd_check("wrap_0", 64'h2000, 64'd0);
    bus_cycle(64'h2000, 64'd5, 1'b1, 1'b1);
    check("rw_same_hit", {63'd0, rd_hit}, 64'd1);
    check("rw_same_old", read_data, 64'd1);
    rd_check("mtime_wr_5", 64'h2000, 64'd5);
    rd_check("mtime_wr_6", 64'h2000, 64'd6);

    // PEND set dominates clear; clear once match is gone
    wr(64'h2010, 64'h0003);
    wr(64'h2008, 64'd0);
    wr(64'h2018, 64'd1);
    rd_check("pend_sticky", 64'h2018, 64'd1);
    check("irq_match", {63'd0, timer_irq}, 64'd1);
    wr(64'h2008, ALL_ONES);
    check("irq_before_clear", {63'd0, timer_irq}, 64'd1);
    wr(64'h2018, 64'd1);
    check("irq_cleared", {63'd0, timer_irq}, 64'd0);
    rd_check("pend_cleared", 64'h2018, 64'd0);

    // Implemented-bit masking
    wr(64'h2010, 64'hFFFF_0000_0000_A5FE);
    rd_check("ctrl_mask", 64'h2010, 64'h0000_0000_0000_A502);
    wr(64'h2018, 64'hFFFF_FFFF_FFFF_FFFE);
    rd_check("status_mask", 64'h2018, 64'd0);
    rd_check("mtime_stop", 64'h2000, 64'd13);

    // Misses
    rd_check("cmp_before_miss", 64'h2008, ALL_ONES);
    bus_cycle(64'h1FF8, 64'd0, 1'b0, 1'b1);
    check("miss_rd_hit", {63'd0, rd_hit}, 64'd0);
    check("miss_hold", read_data, ALL_ONES);
    wr(64'h2020, 64'd0);
    wr(64'h2028, 64'd0);
    rd_check("miss_cmp_kept", 64'h200C, ALL_ONES);
    rd_check("miss_mtime_kept", 64'h2000, 64'd13);

    // Asynchronous reset during a hit load
    @(negedge clk);
    dm_addr = 64'h2008;
    dm_re   = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    dm_re = 1'b0;
    check("rst_mid_rd_hit", {63'd0, rd_hit}, 64'd0);
    check("rst_mid_read_data", read_data, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_check("rst2_ctrl", 64'h2010, 64'd0);
    rd_check("rst2_mtimecmp", 64'h2008, ALL_ONES);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dm_timer.md
# dm_timer

Memory-mapped machine timer that is a responder on the core's data-memory bus. It decodes the same DM_addr / DM_writeData / DM_writeEnable / DM_readEnable signals the core drives toward data memory, and returns read data with the same one-cycle latency as the data RAM. It also produces a level timer-interrupt request for the exception controller's interrupt vector (MTI position).

## Interface
- N, 64, data/address width
- BASE, 64'h2000, byte base address of the 32-byte register window; it sits above the 8 KiB data RAM and is 32-byte aligned
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low reset (reset = 0 resets)
- DM_addr  input  N  byte address from the core
- DM_writeData  input  N  store data, full doubleword
- DM_writeEnable  input  1  store strobe, one cycle per store
- DM_readEnable  input  1  load strobe, one cycle per load
- readData  output  N  registered load data
- rd_hit  output  1  registered; high the cycle readData is valid from this block (system read-mux select)
- timer_irq  output  1  registered level interrupt request

## Operation
- Hit: DM_addr[N-1:5] == BASE[N-1:5]. Register select is DM_addr[4:3]. DM_addr[2:0] is ignored.
- Register map (64-bit):
  - 0x00 MTIME: RW, free-running counter
  - 0x08 MTIMECMP: RW
  - 0x10 CTRL: RW
    - bit0 EN: count enable
    - bit1 IE: interrupt enable
    - bits[15:8] PRESC
    - other bits read 0
  - 0x18 STATUS: bit0 PEND, sticky, write-1-to-clear; other bits read 0 and ignore writes
- Only full doubleword stores are supported. Any write hit replaces the whole register (masked to its implemented bits).
- Prescaler:
  - 8-bit presc_cnt. When EN=1 and presc_cnt == PRESC: presc_cnt <= 0 and MTIME increments; otherwise presc_cnt increments.
  - When EN=0, presc_cnt and MTIME hold.
  - PRESC=0 means MTIME increments every cycle.
- MTIME wraps from 2^64-1 to 0 with no flag.
- Match: match = (MTIME >= MTIMECMP), unsigned compare, evaluated on current register values.
- PEND:
  - Set on any cycle with match=1.
  - Cleared by writing 1 to STATUS bit0 only when match=0 that cycle; set dominates clear.
- timer_irq <= IE & match.
- Simultaneous-event priority:
  - A write to MTIME overrides that cycle's increment, and presc_cnt <= 0.
  - A write to CTRL resets presc_cnt <= 0 that cycle and suppresses that cycle's increment.
  - Read and write to the same register in the same cycle: the write takes effect and readData returns the pre-write value.
- Misses:
  - Accesses outside the window have no effect; rd_hit stays 0 and readData holds.
  - A write to a missing/read-only bit is dropped silently.

## Timing
- Reset values: MTIME=0, MTIMECMP=all ones, CTRL=0, STATUS=0, presc_cnt=0, readData=0, rd_hit=0, timer_irq=0.
- Reset is asynchronous. Asserting it mid-count or mid-read clears everything immediately; a load in flight returns nothing (rd_hit=0).
- Read latency is 1 cycle:
  - DM_readEnable & hit at edge k gives readData = register value sampled at edge k, with rd_hit=1 during cycle k+1.
  - rd_hit is a one-cycle pulse per load. readData holds until the next hit load.
- Write latency: the register updates at the edge where DM_writeEnable & hit is sampled.
- timer_irq lags the match condition by 1 cycle; PEND is set at the same edge as timer_irq.
- Back-to-back loads/stores every cycle are supported, with no stall and no handshake beyond the strobes.

## Test plan
- Reset, then load 0x2000, 0x2008, 0x2010, 0x2018 -> readData = 0, FFFF_FFFF_FFFF_FFFF, 0, 0; rd_hit pulses each cycle after its strobe.
- Write CTRL=0x0003 (PRESC=0), MTIMECMP=10, then wait -> MTIME increments every cycle; timer_irq rises 1 cycle after MTIME reaches 10; PEND=1.
- Write CTRL=0x0301 (PRESC=3) -> MTIME increments exactly every 4 cycles; write CTRL=0 -> MTIME frozen.
- With EN=1, write MTIME=FFFF_FFFF_FFFF_FFFE at PRESC=0 -> reads show ...FFFF, then 0. Writing MTIME=5 while counting -> the next read shows 5 or 6 per latency, never 6 on the write edge.
- With match still true, write STATUS=1 -> PEND stays 1. Then write MTIMECMP=all ones and write STATUS=1 -> PEND=0 and timer_irq=0 one cycle later.
- Load 0x1FF8 and store to 0x2020 -> rd_hit=0, no register changes. Assert reset during a hit load -> rd_hit=0 and readData=0 next cycle.
